cla_pipe: RTL and testbench
===========================

# cla_pipe

Pipelined, parametrised carry-lookahead adder/subtractor built from the existing 4-bit CLA slices. Each stage resolves a group of slices and registers the carry. Operands enter through a valid/ready handshake; results leave through one, with full backpressure. Adds subtract mode, carry-in and signed-overflow reporting. Used wherever wide additions must close timing at the system clock.

## Interface
- `WIDTH`, 8: number of 4-bit slices; datapath is 4*WIDTH bits (N); must be ≥1.
- `GPS`, 2: slices resolved per pipeline stage; 1 ≤ GPS ≤ WIDTH.
- Derived: `NSTAGE` = ceil(WIDTH/GPS).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `ci`  in  1  carry-in; ignored when `sub`=1.
- `sub`  in  1  1: compute a − b as a + ~b + 1.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result this cycle.
- `s`  out  N  sum/difference.
- `c`  out  1  carry out of bit N−1 (for sub: 1 = no borrow).
- `v`  out  1  two's-complement overflow.

## Operation
- Transfer happens on any edge where valid && ready; `a`, `b`, `ci`, `sub` are sampled only then.
- At acceptance: b' = sub ? ~b : b; c0 = sub ? 1 : ci; `v` is computed from the sign bits and carried down the pipe: v = (a[N−1] == b'[N−1]) && (s[N−1] != a[N−1]).
- Stage k (0 ≤ k < NSTAGE) resolves slices [k*GPS, min((k+1)*GPS, WIDTH)) with cla_4 instances chained on the registered carry from stage k−1 (c0 for stage 0). It registers:
  - the sum bits produced so far;
  - the operand bits not yet consumed;
  - the outgoing carry;
  - the precomputed sign bits;
  - a valid flag.
- Last stage: for non-divisible WIDTH it holds fewer slices; it is otherwise identical.
- Stage advance rule: stage k loads from stage k−1 (or input) when stage k is empty or stage k is moving forward this cycle. Last stage moves forward when out_valid && out_ready.
- `in_ready` = !valid[0] || stage 0 moving forward. This is a combinational ready chain from `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Bubbles collapse: an empty stage accepts regardless of downstream state.
- Ordering is strict FIFO; capacity is NSTAGE results.
- Arithmetic is modulo 2^N; `c` and `v` are the only indication of wrap.
- `s`, `c`, `v` are held stable while out_valid && !out_ready.

## Timing
- Reset (rst=1 at an edge):
  - all stage valid flags and data registers clear;
  - out_valid=0, s=0, c=0, v=0;
  - `in_ready`=0 while rst is high, 1 on the first cycle after rst falls.
- Reset mid-operation: all in-flight results are discarded silently. No partial output.
- Latency: operands accepted at edge t produce out_valid=1 in the cycle after edge t+NSTAGE−1 (i.e. NSTAGE cycles), with no backpressure.
- Throughput: one result per cycle with out_ready held 1.
- Full pipe with out_ready=0: in_ready=0. Raising out_ready for a cycle frees one slot the same cycle, so in_ready=1 combinationally.
- Simultaneous accept-and-emit on a full pipe is permitted and keeps occupancy constant.
- in_valid with in_ready=0 has no effect. The source must hold its data until accepted.

## Structure
- Shared package `cla_pkg`: function computing NSTAGE from WIDTH/GPS; stage record typedef (valid, sum, rem_a, rem_b, carry, sa, sb).
- Sub-module: the existing `cla_4` slice, instantiated GPS times per stage via generate.
- No other hierarchy; the stage control (valid/advance) lives in cla_pipe.

## Test plan
All scenarios use WIDTH=8, GPS=2 (N=32, NSTAGE=4) unless noted.
- Carry wrap: a=0xFFFFFFFF, b=0x00000001, sub=0, ci=0, out_ready=1.
  - Expect s=0x00000000, c=1, v=0.
  - out_valid exactly 4 cycles after acceptance.
- Signed overflow: a=0x7FFFFFFF, b=1.
  - Expect s=0x80000000, c=0, v=1.
- Subtract:
  - a=5, b=7, sub=1, ci=1 → s=0xFFFFFFFE, c=0, v=0 (ci ignored).
  - a=7, b=5 → s=2, c=1.
- Backpressure:
  - Stimulus: 10 back-to-back random pairs; out_ready=0 for cycles 3–10.
  - Expect in_ready=0 once 4 results are held.
  - Expect all 10 results in order, each matching a reference model, with s/c/v stable while stalled.
- Reset mid-stream: rst pulsed for 1 cycle with 3 results in flight.
  - Expect out_valid=0 the cycle after, no stale result ever emitted.
  - Expect the next accepted pair to emit after 4 cycles.
- Non-divisible depth: WIDTH=3, GPS=2 (NSTAGE=2), a=0xFFF, b=0x001.
  - Expect s=0x000, c=1, latency 2.
  - Random sweep of 1000 pairs matches the model.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   cla_nstage()  - number of pipeline stages for a given slice count / group size
//   stage_ctl_t   - per-stage control record (valid, carry, operand sign bits)
package cla_pkg;

  // Control part of a stage record; the width-dependent data fields are added
  // by cla_pipe, which knows N.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sa;
    logic sb;
  } stage_ctl_t;

  // ceil(width / gps)
  function automatic int unsigned cla_nstage(input int unsigned width, input int unsigned gps);
    return (width + gps - 1) / gps;
  endfunction

  // One past the last slice resolved by stage k.
  function automatic int unsigned cla_stage_hi(input int unsigned k, input int unsigned width,
                                               input int unsigned gps);
    return ((k + 1) * gps > width) ? width : (k + 1) * gps;
  endfunction

endpackage

// File: rtl/cla_4.sv
// cla_4: 4-bit carry-lookahead adder slice.
//   i_a, i_b : 4-bit operands
//   i_ci     : carry in
//   o_s      : 4-bit sum
//   o_co     : carry out
module cla_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Flattened lookahead: every carry is a two-level function of g/p and i_ci.
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_co = w_c[4];

endmodule

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined 4*WIDTH-bit carry-lookahead adder/subtractor with
// valid/ready handshakes on both sides and full backpressure.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, ci, sub)
//   out_valid/out_ready : result handshake (s, c, v)
//   c                   : carry out of bit N-1 (for subtract: 1 = no borrow)
//   v                   : two's-complement overflow
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GPS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   a,
  input  logic [4*WIDTH-1:0]   b,
  input  logic                 ci,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   s,
  output logic                 c,
  output logic                 v
);

  localparam int unsigned N      = 4 * WIDTH;
  localparam int unsigned NSTAGE = cla_nstage(WIDTH, GPS);
  localparam int unsigned LAST   = NSTAGE - 1;

  typedef struct packed {
    logic [N-1:0] sum;
    logic [N-1:0] rem_a;
    logic [N-1:0] rem_b;
    stage_ctl_t   ctl;
  } stage_t;

  stage_t r_stage [NSTAGE];
  stage_t w_src   [NSTAGE];
  stage_t w_nxt   [NSTAGE];
  stage_t w_in;

  logic [NSTAGE-1:0] w_move;
  logic [NSTAGE-1:0] w_load;
  logic [N-1:0]      w_b_eff;
  logic              w_accept;

  // Operand conditioning at acceptance: subtract is a + ~b + 1.
  assign w_b_eff  = sub ? ~b : b;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_in           = '0;
    w_in.rem_a     = a;
    w_in.rem_b     = w_b_eff;
    w_in.ctl.valid = w_accept;
    w_in.ctl.carry = sub | ci;
    w_in.ctl.sa    = a[N-1];
    w_in.ctl.sb    = w_b_eff[N-1];
  end

  // Ready chain, evaluated from the output back towards the input.
  always_comb begin
    w_move       = '0;
    w_load       = '0;
    w_move[LAST] = r_stage[LAST].ctl.valid & out_ready;
    for (int k = int'(NSTAGE) - 2; k >= 0; k--) begin
      w_move[k] = r_stage[k].ctl.valid & (~r_stage[k+1].ctl.valid | w_move[k+1]);
    end
    for (int k = 0; k < int'(NSTAGE); k++) begin
      w_load[k] = ~r_stage[k].ctl.valid | w_move[k];
    end
  end

  assign in_ready = ~rst & w_load[0];

  // Per-stage slice datapath.
  for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
    localparam int LO  = k * int'(GPS);
    localparam int HI  = int'(cla_stage_hi(k, WIDTH, GPS));
    localparam int CNT = HI - LO;

    logic [CNT:0] w_chain;
    logic [N-1:0] w_sum;

    if (k == 0) begin : g_src_in
      assign w_src[k] = w_in;
    end else begin : g_src_prev
      assign w_src[k] = r_stage[k-1];
    end

    assign w_chain[0] = w_src[k].ctl.carry;

    // Slices owned by this stage are computed; all others pass through.
    for (genvar j = 0; j < int'(WIDTH); j++) begin : g_slice
      if (j >= LO && j < HI) begin : g_cla
        cla_4 u_cla (
          .i_a  (w_src[k].rem_a[4*j +: 4]),
          .i_b  (w_src[k].rem_b[4*j +: 4]),
          .i_ci (w_chain[j-LO]),
          .o_s  (w_sum[4*j +: 4]),
          .o_co (w_chain[j-LO+1])
        );
      end else begin : g_pass
        assign w_sum[4*j +: 4] = w_src[k].sum[4*j +: 4];
      end
    end

    assign w_nxt[k] = stage_t'({w_sum, w_src[k].rem_a, w_src[k].rem_b,
                                w_src[k].ctl.valid, w_chain[CNT],
                                w_src[k].ctl.sa, w_src[k].ctl.sb});
  end

  // Stage registers: load on empty-or-moving; an invalid upstream only clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        if (w_load[k]) begin
          if (w_src[k].ctl.valid) begin
            r_stage[k] <= w_nxt[k];
          end else begin
            r_stage[k].ctl.valid <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid = r_stage[LAST].ctl.valid;
  assign s         = r_stage[LAST].sum;
  assign c         = r_stage[LAST].ctl.carry;
  // Overflow: operands share a sign that the result does not.
  assign v         = (r_stage[LAST].ctl.sa == r_stage[LAST].ctl.sb) &
                     (r_stage[LAST].sum[N-1] != r_stage[LAST].ctl.sa);

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: scoreboard bench for cla_pipe with two configurations
// (WIDTH=8/GPS=2 and WIDTH=3/GPS=2).
module tb_cla_pipe;

  localparam int unsigned W0 = 8, G0 = 2, N0 = 32, NS0 = 4;
  localparam int unsigned W1 = 3, G1 = 2, N1 = 12, NS1 = 2;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv0, ir0, ci0, sub0, ov0, or0, c0, v0;
  logic [N0-1:0] a0, b0, s0;
  logic iv1, ir1, ci1, sub1, ov1, or1, c1, v1;
  logic [N1-1:0] a1, b1, s1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   fails  = 0;
  int   occ0   = 0;
  int   occ1   = 0;
  bit   lat0   = 0;
  bit   lat1   = 0;

  cla_pipe #(.WIDTH(W0), .GPS(G0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .ci(ci0),
    .sub(sub0), .out_valid(ov0), .out_ready(or0), .s(s0), .c(c0), .v(v0)
  );

  cla_pipe #(.WIDTH(W1), .GPS(G1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .ci(ci1),
    .sub(sub1), .out_valid(ov1), .out_ready(or1), .s(s1), .c(c1), .v(v1)
  );

  // Reference: plain integer arithmetic on an n-bit machine.
  function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    exp_t   e;
    longint m, ua, ub, sa, sb, tot, tr;
    m   = longint'(1) << n;
    ua  = longint'({32'b0, a}) & (m - 1);
    ub  = longint'({32'b0, b}) & (m - 1);
    tot = sub ? (ua - ub + m) : (ua + ub + longint'(ci));
    e.s = 32'(tot & (m - 1));
    e.c = (tot >= m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    tr  = sub ? (sa - sb) : (sa + sb + longint'(ci));
    e.v = (tr < -(m / 2)) || (tr >= m / 2);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int now();
    return int'($time / 10);
  endfunction

  // Monitor / scoreboard for configuration 0.
  initial begin : mon0
    exp_t          e;
    bit            hold;
    logic [N0-1:0] hs;
    logic          hc, hv;
    hold = 0; hs = '0; hc = 0; hv = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.delete(); occ0 = 0; hold = 0;
        chk("rst_in_ready0", 64'(ir0), 64'(0));
      end else begin
        chk("in_ready_rule0", 64'(ir0), 64'((occ0 < int'(NS0)) || or0));
        if (hold) begin
          chk("stall_valid0", 64'(ov0), 64'(1));
          chk("stall_s0", 64'(s0), 64'(hs));
          chk("stall_cv0", 64'({c0, v0}), 64'({hc, hv}));
        end
        if (ov0 && or0) begin
          if (q0.size() == 0) begin
            checks++; fails++;
            $display("FAIL stale0: got result s=%0h, expected no output", s0);
          end else begin
            e = q0.pop_front();
            chk("sum0", 64'(s0), 64'(e.s[N0-1:0]));
            chk("carry_ovf0", 64'({c0, v0}), 64'({e.c, e.v}));
            if (e.lat) chk("latency0", 64'(now() - e.acc), 64'(NS0));
            occ0--;
          end
        end
        hold = ov0 && !or0; hs = s0; hc = c0; hv = v0;
        if (iv0 && ir0) begin
          e = model(int'(N0), a0, b0, ci0, sub0);
          e.acc = now(); e.lat = lat0;
          q0.push_back(e); occ0++;
        end
      end
    end
  end

  // Monitor / scoreboard for configuration 1.
  initial begin : mon1
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        q1.delete(); occ1 = 0;
      end else begin
        chk("in_ready_rule1", 64'(ir1), 64'((occ1 < int'(NS1)) || or1));
        if (ov1 && or1) begin
          if (q1.size() == 0) begin
            checks++; fails++;
            $display("FAIL stale1: got result s=%0h, expected no output", s1);
          end else begin
            e = q1.pop_front();
            chk("sum1", 64'(s1), 64'(e.s[N1-1:0]));
            chk("carry_ovf1", 64'({c1, v1}), 64'({e.c, e.v}));
            if (e.lat) chk("latency1", 64'(now() - e.acc), 64'(NS1));
            occ1--;
          end
        end
        if (iv1 && ir1) begin
          e = model(int'(N1), 32'(a1), 32'(b1), ci1, sub1);
          e.acc = now(); e.lat = lat1;
          q1.push_back(e); occ1++;
        end
      end
    end
  end

  // Drivers: called at a falling edge, return at the falling edge after acceptance.
  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
    bit done;
    done = 0;
    a0 = a; b0 = b; ci0 = ci; sub0 = sub; iv0 = 1;
    for (int t = 0; t < 500 && !done; t++) begin
      #1 done = ir0;
      @(negedge clk);
    end
    iv0 = 0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL send0_timeout: in_ready stayed 0, expected acceptance");
    end
  endtask

  task automatic send1(input logic [11:0] a, input logic [11:0] b, input logic ci, input logic sub);
    bit done;
    done = 0;
    a1 = a; b1 = b; ci1 = ci; sub1 = sub; iv1 = 1;
    for (int t = 0; t < 500 && !done; t++) begin
      #1 done = ir1;
      @(negedge clk);
    end
    iv1 = 0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL send1_timeout: in_ready stayed 0, expected acceptance");
    end
  endtask

  task automatic drain0();
    or0 = 1;
    for (int t = 0; t < 1000 && occ0 != 0; t++) @(negedge clk);
    if (occ0 != 0) begin
      checks++; fails++;
      $display("FAIL drain0_timeout: %0d results outstanding, expected 0", occ0);
    end
  endtask

  task automatic drain1();
    or1 = 1;
    for (int t = 0; t < 1000 && occ1 != 0; t++) @(negedge clk);
    if (occ1 != 0) begin
      checks++; fails++;
      $display("FAIL drain1_timeout: %0d results outstanding, expected 0", occ1);
    end
  endtask

  // Single operation into an empty pipe, checked against fixed expected values.
  task automatic directed0(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sub,
                           input logic [31:0] es, input logic ec, input logic ev);
    bit seen;
    seen = 0;
    lat0 = 1;
    send0(a, b, ci, sub);
    lat0 = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (ov0) seen = 1;
      else @(negedge clk);
    end
    chk({nm, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({nm, "_s"}, 64'(s0), 64'(es));
      chk({nm, "_cv"}, 64'({c0, v0}), 64'({ec, ev}));
    end
    drain0();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit stop;
    rst = 1;
    iv0 = 0; a0 = '0; b0 = '0; ci0 = 0; sub0 = 0; or0 = 1;
    iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; sub1 = 0; or1 = 1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(ov0), 64'(0));
    chk("reset_s", 64'(s0), 64'(0));
    chk("reset_cv", 64'({c0, v0}), 64'(0));
    chk("reset_in_ready", 64'(ir0), 64'(0));
    rst = 0;
    #1 chk("in_ready_after_reset", 64'(ir0), 64'(1));
    @(negedge clk);

    directed0("carry_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed0("signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed0("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed0("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);

    // Backpressure: ten back-to-back pairs, consumer stalled for cycles 3-10.
    fork
      begin
        for (int i = 0; i < 10; i++) send0($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      begin
        repeat (2) @(negedge clk);
        or0 = 0;
        repeat (6) @(negedge clk);
        #1 chk("full_in_ready", 64'(ir0), 64'(0));
        chk("full_out_valid", 64'(ov0), 64'(1));
        repeat (2) @(negedge clk);
        or0 = 1;
      end
    join
    drain0();

    // Reset with three results in flight.
    or0 = 0;
    for (int i = 0; i < 3; i++) send0($urandom, $urandom, 1'($urandom), 1'($urandom));
    rst = 1;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(ov0), 64'(0));
    chk("rst_mid_in_ready", 64'(ir0), 64'(0));
    rst = 0;
    or0 = 1;
    #1 chk("rst_mid_in_ready_after", 64'(ir0), 64'(1));
    @(negedge clk);
    directed0("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    // Random traffic with random consumer stalls.
    stop = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          send0($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          or0 = ($urandom_range(0, 2) != 0);
          @(negedge clk);
        end
      end
    join
    drain0();

    // Non-divisible depth: WIDTH=3, GPS=2.
    lat1 = 1;
    send1(12'hFFF, 12'h001, 1'b0, 1'b0);
    lat1 = 0;
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        if (ov1) seen = 1;
        else @(negedge clk);
      end
      chk("w3_seen", 64'(seen), 64'(1));
      if (seen) begin
        chk("w3_s", 64'(s1), 64'(0));
        chk("w3_cv", 64'({c1, v1}), 64'({1'b1, 1'b0}));
      end
    end
    drain1();

    stop = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) send1(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
        stop = 1;
      end
      begin
        while (!stop) begin
          or1 = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    drain1();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
